iq_playback_control: RTL and testbench
======================================

IQ_PLAYBACK_CONTROL -- requirements
Module: iq_playback_control

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, BRAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, IQ word width ({I[15:0],Q[15:0]}).
REQ-003 SHALL have parameter SAMPLE_COUNT, default 40000, words played per second; range 2..2^ADDR_W.
REQ-004 SHALL have parameter RD_LATENCY, default 2, BRAM read latency in cycles; legal values 1 or 2.
REQ-005 SHALL have ports:
  clk  in  1  clock (adc_clk domain)
  rst  in  1  reset, synchronous, active-high
  one_sec_pulse  in  1  second marker; level, rising edge significant
  cic_pulse  in  1  single-cycle interpolator sample request
  enable  in  1  playback permitted
  rd_en  out  1  BRAM read strobe
  rd_addr  out  ADDR_W  BRAM read address
  rd_data  in  DATA_W  BRAM read data
  iq_data  out  DATA_W  output sample
  iq_valid  out  1  iq_data valid
  iq_ready  in  1  consumer accepts
  busy  out  1  high in PLAY or DRAIN
  done  out  1  one-cycle pulse on normal completion
  overrun  out  1  one-cycle pulse when unconsumed sample is overwritten
  err_count  out  16  overrun count (see Configuration)

Function
REQ-006 SHALL register one_sec_pulse each cycle; sec_edge = one_sec_pulse & ~previous.
REQ-007 SHALL implement states IDLE, PLAY, DRAIN.
REQ-008 IDLE: sec_edge & enable -> PLAY, address counter := 0; otherwise remain in IDLE.
REQ-009 PLAY: each cycle with cic_pulse=1 SHALL assert rd_en for exactly one cycle, registered, with rd_addr = counter, then increment counter.
REQ-010 The read issued with counter = SAMPLE_COUNT-1 SHALL be the last; state -> DRAIN in the following cycle.
REQ-011 DRAIN: remain until all in-flight reads have returned, then -> IDLE with done=1 for one cycle.
REQ-012 rd_data SHALL be captured into iq_data exactly RD_LATENCY cycles after the rd_en cycle, with iq_valid set in the same cycle.
REQ-013 iq_valid SHALL clear on the cycle after iq_valid & iq_ready, unless a new capture occurs in that cycle, in which case iq_valid stays 1 with the new data.
REQ-014 A capture while iq_valid=1 and iq_ready=0 SHALL overwrite iq_data and pulse overrun for one cycle.
REQ-015 sec_edge in PLAY or DRAIN with enable=1 SHALL restart: counter := 0, state := PLAY; in-flight reads still deliver; done not pulsed.
REQ-016 cic_pulse coincident with a restarting sec_edge SHALL be ignored; the first read uses address 0 on a later pulse.
REQ-017 enable=0 in PLAY SHALL stop issuing reads; state -> DRAIN; no done pulse on abort.
REQ-018 cic_pulse in IDLE or DRAIN SHALL be ignored.
REQ-019 rd_addr SHALL hold its last value when rd_en=0.
REQ-020 rd_addr SHALL never exceed SAMPLE_COUNT-1.

Reset
REQ-021 On rst: state IDLE; counter, rd_addr, iq_data and err_count = 0; rd_en, iq_valid, busy, done and overrun = 0; edge register = 0.
REQ-022 rst mid-playback SHALL discard in-flight reads; no capture occurs after rst is sampled.
REQ-023 A one_sec_pulse held high through reset release SHALL NOT be treated as an edge.

Configuration
REQ-024 With IQ_PLAYBACK_ERR_CNT_EN defined, err_count SHALL increment on each overrun pulse and saturate at 16'hFFFF.
REQ-025 Without IQ_PLAYBACK_ERR_CNT_EN, err_count SHALL be tied to 0; overrun pulses are unaffected.

Verification
REQ-026 SAMPLE_COUNT=8, RD_LATENCY=2, iq_ready=1, enable=1, sec_edge, then 8 cic_pulses spaced 10 cycles -> rd_addr 0..7, each iq_data equal to the BRAM word 2 cycles after its rd_en, done one cycle after last capture, busy low.
REQ-027 iq_ready=0, two cic_pulses -> one overrun pulse, iq_data = word 1, err_count=1 with macro defined and 0 without.
REQ-028 sec_edge after address 3 was read -> next read at address 0, no done pulse, busy stays 1.
REQ-029 enable dropped after address 2 was read -> no further rd_en, pending word delivered, IDLE with done=0.
REQ-030 rst asserted one cycle after rd_en -> no iq_valid afterwards; one_sec_pulse held high across release -> stays IDLE until a fresh rising edge.

Source files
------------

// File: rtl/iq_playback_control_if.sv
// BRAM read port and IQ sample stream of iq_playback_control.
// The master side is the controller; the slave side is the BRAM plus the sample consumer.
interface iq_playback_control_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] iq_data;
  logic              iq_valid;
  logic              iq_ready;

  modport master (output rd_en, rd_addr, iq_data, iq_valid, input rd_data, iq_ready);
  modport slave  (input rd_en, rd_addr, iq_data, iq_valid, output rd_data, iq_ready);
endinterface

// File: rtl/iq_playback_control.sv
// Plays SAMPLE_COUNT BRAM words per second marker, one per cic_pulse; iq_valid RD_LATENCY+1 cycles after the pulse.
// Unconsumed samples are overwritten (overrun pulse); the err_count saturating counter exists only with IQ_PLAYBACK_ERR_CNT_EN.
module iq_playback_control #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int SAMPLE_COUNT = 40000,
  parameter int RD_LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 one_sec_pulse,
  input  logic                 cic_pulse,
  input  logic                 enable,
  iq_playback_control_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [15:0]          err_count
);
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_e;

  localparam logic [ADDR_W-1:0]     LAST_ADDR  = ADDR_W'(SAMPLE_COUNT - 1);
  localparam logic [RD_LATENCY-1:0] EARLY_MASK = {RD_LATENCY{1'b1}} >> 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic                sec_prev_q, armed_q;
  logic [RD_LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]   iq_data_q;
  logic                iq_valid_q;
  logic                overrun_q;
  logic                sec_edge, capture, in_flight, overrun_d;

  // armed_q blocks a marker that was already high when reset released
  assign sec_edge  = one_sec_pulse & ~sec_prev_q & armed_q;
  assign capture   = vld_q[RD_LATENCY-1];
  assign in_flight = rd_en_q | (|(vld_q & EARLY_MASK));
  assign overrun_d = capture & iq_valid_q & ~bus.iq_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    abort_d   = abort_q;
    case (state_q)
      IDLE: begin
        if (sec_edge && enable) begin
          state_d = PLAY;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      PLAY: begin
        if (sec_edge && enable) begin
          cnt_d = '0;
        end else if (!enable) begin
          state_d = DRAIN;
          abort_d = 1'b1;
        end else if (cic_pulse) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q;
          if (cnt_q == LAST_ADDR) state_d = DRAIN;
          else cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (sec_edge && enable) begin
          state_d = PLAY;
          cnt_d   = '0;
          abort_d = 1'b0;
        end else if (!in_flight) begin
          // the last in-flight word is captured on this same edge
          state_d = IDLE;
          done_d  = ~abort_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      sec_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      vld_q      <= '0;
      iq_data_q  <= '0;
      iq_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      sec_prev_q <= one_sec_pulse;
      armed_q    <= armed_q | ~one_sec_pulse;
      vld_q      <= RD_LATENCY'({vld_q, rd_en_q});
      overrun_q  <= overrun_d;
      if (capture) begin
        iq_data_q  <= bus.rd_data;
        iq_valid_q <= 1'b1;
      end else if (iq_valid_q && bus.iq_ready) begin
        iq_valid_q <= 1'b0;
      end
    end
  end

`ifdef IQ_PLAYBACK_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else if (overrun_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'd0;
`endif

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.iq_data  = iq_data_q;
  assign bus.iq_valid = iq_valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_iq_playback_control.sv
// Bench for iq_playback_control: BRAM model with 2-cycle read latency, negedge event monitor,
// expected addresses queued as pulses are driven and compared against what the DUT reads and delivers.
module tb_iq_playback_control;
  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int SAMPLE_COUNT = 8;
  localparam int RD_LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        one_sec_pulse;
  logic        cic_pulse;
  logic        enable;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  iq_playback_control_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iq_playback_control #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_COUNT(SAMPLE_COUNT), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .one_sec_pulse(one_sec_pulse), .cic_pulse(cic_pulse),
    .enable(enable), .bus(bus), .busy(busy), .done(done), .overrun(overrun),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] bram_word(input logic [ADDR_W-1:0] a);
    return {a ^ 16'h5A5A, a + 16'h1234};
  endfunction

  // BRAM: address registered, then data registered -> word visible 2 cycles after rd_en
  logic [ADDR_W-1:0] bram_addr_q;
  always @(posedge clk) begin
    bram_addr_q <= bus.rd_addr;
    bus.rd_data <= bram_word(bram_addr_q);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] rd_addr_log[$];
  int                rd_cyc_log[$];
  logic [DATA_W-1:0] cap_data_log[$];
  int                cap_cyc_log[$];
  int                done_log[$];
  int                overrun_cnt, valid_cnt, busy_low_cnt;

  always @(negedge clk) begin
    if (bus.rd_en === 1'b1) begin
      rd_addr_log.push_back(bus.rd_addr);
      rd_cyc_log.push_back(cyc);
    end
    if (bus.iq_valid === 1'b1 && bus.iq_ready === 1'b1) begin
      cap_data_log.push_back(bus.iq_data);
      cap_cyc_log.push_back(cyc);
    end
    if (bus.iq_valid === 1'b1) valid_cnt++;
    if (done === 1'b1) done_log.push_back(cyc);
    if (overrun === 1'b1) overrun_cnt++;
    if (busy !== 1'b1) busy_low_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr_log.delete(); rd_cyc_log.delete();
    cap_data_log.delete(); cap_cyc_log.delete();
    done_log.delete();
    overrun_cnt = 0; valid_cnt = 0; busy_low_cnt = 0;
  endtask

  task automatic pulse_cic();
    cic_pulse = 1'b1; tick(1); cic_pulse = 1'b0;
  endtask

  task automatic start_play();
    one_sec_pulse = 1'b0; tick(2);
    one_sec_pulse = 1'b1; tick(2);
    one_sec_pulse = 1'b0; tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; one_sec_pulse = 1'b0; cic_pulse = 1'b0; enable = 1'b0; bus.iq_ready = 1'b1;
    tick(3);
    total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b want 0", bus.rd_en); end
    total++; if (bus.rd_addr !== '0) begin bad++; $display("FAIL rst_rd_addr: got %0h want 0", bus.rd_addr); end
    total++; if (bus.iq_data !== '0) begin bad++; $display("FAIL rst_iq_data: got %0h want 0", bus.iq_data); end
    total++; if (bus.iq_valid !== 1'b0) begin bad++; $display("FAIL rst_iq_valid: got %b want 0", bus.iq_valid); end
    total++; if ({busy, done, overrun} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {busy, done, overrun}); end
    total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_playback();
    logic [ADDR_W-1:0] exp_addr[$];
    logic [ADDR_W-1:0] e;
    int last;
    clear_logs(); enable = 1'b1; bus.iq_ready = 1'b1;
    start_play();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL play_busy: got %b want 1", busy); end
    for (int i = 0; i < SAMPLE_COUNT; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      pulse_cic(); tick(9);
    end
    for (int k = 0; k < 30 && done_log.size() == 0; k++) tick(1);
    tick(3);
    total++; if (rd_addr_log.size() != SAMPLE_COUNT) begin bad++; $display("FAIL play_reads: got %0d want %0d", rd_addr_log.size(), SAMPLE_COUNT); end
    total++; if (cap_data_log.size() != SAMPLE_COUNT) begin bad++; $display("FAIL play_caps: got %0d want %0d", cap_data_log.size(), SAMPLE_COUNT); end
    for (int i = 0; i < rd_addr_log.size() && i < cap_data_log.size() && exp_addr.size() > 0; i++) begin
      e = exp_addr.pop_front();
      total++; if (rd_addr_log[i] !== e) begin bad++; $display("FAIL play_addr[%0d]: got %0h want %0h", i, rd_addr_log[i], e); end
      total++; if (cap_data_log[i] !== bram_word(e)) begin bad++; $display("FAIL play_data[%0d]: got %0h want %0h", i, cap_data_log[i], bram_word(e)); end
      total++; if (cap_cyc_log[i] != rd_cyc_log[i] + RD_LATENCY + 1) begin bad++; $display("FAIL play_lat[%0d]: got %0d want %0d", i, cap_cyc_log[i] - rd_cyc_log[i], RD_LATENCY + 1); end
    end
    total++;
    if (done_log.size() != 1) begin
      bad++; $display("FAIL play_done_cnt: got %0d want 1", done_log.size());
    end else if (cap_cyc_log.size() > 0) begin
      last = cap_cyc_log[cap_cyc_log.size() - 1];
      total++; if (done_log[0] != last) begin bad++; $display("FAIL play_done_cyc: got %0d want %0d", done_log[0], last); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL play_busy_end: got %b want 0", busy); end
    total++; if (bus.rd_addr !== ADDR_W'(SAMPLE_COUNT - 1)) begin bad++; $display("FAIL play_addr_hold: got %0h want %0h", bus.rd_addr, SAMPLE_COUNT - 1); end
    clear_logs(); pulse_cic(); tick(6);
    total++; if (rd_addr_log.size() != 0) begin bad++; $display("FAIL idle_cic: got %0d reads want 0", rd_addr_log.size()); end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_err;
`ifdef IQ_PLAYBACK_ERR_CNT_EN
    exp_err = 16'd1;
`else
    exp_err = 16'd0;
`endif
    clear_logs(); enable = 1'b1; bus.iq_ready = 1'b0;
    start_play();
    pulse_cic(); tick(9);
    total++; if (overrun_cnt != 0) begin bad++; $display("FAIL ovr_first: got %0d pulses want 0", overrun_cnt); end
    pulse_cic(); tick(9);
    total++; if (overrun_cnt != 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", overrun_cnt); end
    total++; if (bus.iq_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", bus.iq_valid); end
    total++; if (bus.iq_data !== bram_word(ADDR_W'(1))) begin bad++; $display("FAIL ovr_data: got %0h want %0h", bus.iq_data, bram_word(ADDR_W'(1))); end
    total++; if (err_count !== exp_err) begin bad++; $display("FAIL ovr_err_count: got %0d want %0d", err_count, exp_err); end
    enable = 1'b0; tick(5);
    bus.iq_ready = 1'b1; tick(2);
    total++; if (bus.iq_valid !== 1'b0) begin bad++; $display("FAIL ovr_consumed: got %b want 0", bus.iq_valid); end
    total++; if (done_log.size() != 0) begin bad++; $display("FAIL ovr_abort_done: got %0d want 0", done_log.size()); end
  endtask

  task automatic test_restart();
    logic [ADDR_W-1:0] exp_addr[$];
    logic [ADDR_W-1:0] e;
    clear_logs(); enable = 1'b1; bus.iq_ready = 1'b1;
    start_play();
    busy_low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      pulse_cic();
      if (i < 3) tick(9);
    end
    // address 3 still in flight; marker edge and a pulse land together
    tick(1);
    one_sec_pulse = 1'b1; cic_pulse = 1'b1; tick(1);
    one_sec_pulse = 1'b0; cic_pulse = 1'b0; tick(9);
    exp_addr.push_back(ADDR_W'(0));
    pulse_cic(); tick(9);
    total++; if (rd_addr_log.size() != 5) begin bad++; $display("FAIL rs_reads: got %0d want 5", rd_addr_log.size()); end
    total++; if (cap_data_log.size() != 5) begin bad++; $display("FAIL rs_caps: got %0d want 5", cap_data_log.size()); end
    for (int i = 0; i < rd_addr_log.size() && i < cap_data_log.size() && exp_addr.size() > 0; i++) begin
      e = exp_addr.pop_front();
      total++; if (rd_addr_log[i] !== e) begin bad++; $display("FAIL rs_addr[%0d]: got %0h want %0h", i, rd_addr_log[i], e); end
      total++; if (cap_data_log[i] !== bram_word(e)) begin bad++; $display("FAIL rs_data[%0d]: got %0h want %0h", i, cap_data_log[i], bram_word(e)); end
    end
    total++; if (done_log.size() != 0) begin bad++; $display("FAIL rs_done: got %0d want 0", done_log.size()); end
    total++; if (busy_low_cnt != 0) begin bad++; $display("FAIL rs_busy: got %0d low cycles want 0", busy_low_cnt); end
    enable = 1'b0; tick(8);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rs_idle: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    clear_logs(); enable = 1'b1; bus.iq_ready = 1'b1;
    start_play();
    for (int i = 0; i < 3; i++) begin
      pulse_cic();
      if (i < 2) tick(9);
    end
    tick(1);
    enable = 1'b0; tick(3);
    pulse_cic(); tick(4); pulse_cic(); tick(10);
    total++; if (rd_addr_log.size() != 3) begin bad++; $display("FAIL ab_reads: got %0d want 3", rd_addr_log.size()); end
    total++; if (cap_data_log.size() != 3) begin bad++; $display("FAIL ab_caps: got %0d want 3", cap_data_log.size()); end
    if (cap_data_log.size() == 3) begin
      total++; if (cap_data_log[2] !== bram_word(ADDR_W'(2))) begin bad++; $display("FAIL ab_pending: got %0h want %0h", cap_data_log[2], bram_word(ADDR_W'(2))); end
    end
    total++; if (done_log.size() != 0) begin bad++; $display("FAIL ab_done: got %0d want 0", done_log.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_idle: got %b want 0", busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    clear_logs(); enable = 1'b1; bus.iq_ready = 1'b1;
    one_sec_pulse = 1'b0; tick(2);
    one_sec_pulse = 1'b1; tick(3);
    pulse_cic(); tick(1);
    rst = 1'b1; clear_logs(); tick(2);
    rst = 1'b0; tick(1);
    total++; if (bus.iq_data !== '0) begin bad++; $display("FAIL rm_iq_data: got %0h want 0", bus.iq_data); end
    tick(6); pulse_cic(); tick(8);
    total++; if (valid_cnt != 0) begin bad++; $display("FAIL rm_valid: got %0d cycles want 0", valid_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_held_edge: got busy %b want 0", busy); end
    total++; if (rd_addr_log.size() != 0) begin bad++; $display("FAIL rm_reads: got %0d want 0", rd_addr_log.size()); end
    one_sec_pulse = 1'b0; tick(2);
    one_sec_pulse = 1'b1; tick(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_fresh_edge: got busy %b want 1", busy); end
    pulse_cic(); tick(9);
    total++; if (rd_addr_log.size() != 1) begin bad++; $display("FAIL rm_new_reads: got %0d want 1", rd_addr_log.size()); end
    else begin
      total++; if (rd_addr_log[0] !== '0) begin bad++; $display("FAIL rm_new_addr: got %0h want 0", rd_addr_log[0]); end
    end
    total++; if (cap_data_log.size() != 1 || cap_data_log[0] !== bram_word('0)) begin
      bad++; $display("FAIL rm_new_data: got %0d words want 1 word %0h", cap_data_log.size(), bram_word('0));
    end
    enable = 1'b0; one_sec_pulse = 1'b0; tick(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by time %0t want summary", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_playback();
    test_overrun();
    test_restart();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
